deserializer: RTL

Serial-to-parallel receiver, the far end of the serializer link. Collects an MSB-first bit stream qualified by a valid strobe into `DATA_W`-bit words and emits each word with a length code that uses the serializer's `data_mod` encoding. Partial words, illegal lengths and stalled transfers are detected and reported. It sits directly on the serial output of a serializer, or on any link carrying the same protocol.

---
 rtl/deserializer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// ============================================================================
//  Module      : deserializer
//  Description : Serial-to-parallel receiver for an MSB-first, valid-qualified
//                bit stream with length codes and error reporting.
//                Optional feature macro: DESERIALIZER_LAST_EN (last-bit strobe).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer #(
  parameter int DATA_W        = 16,
  parameter int MOD_W         = $clog2(DATA_W),
  parameter int MOD_IGNORE_LO = 1,
  parameter int MOD_IGNORE_HI = 2,
  parameter int GAP_TIMEOUT   = 32
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
`ifdef DESERIALIZER_LAST_EN
  input  logic              ser_data_last_i,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic [MOD_W-1:0]  data_mod_o,
  output logic              data_val_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int N_W    = CNT_W + 1;
  localparam int IDLE_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_cnt_top = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [MOD_W-1:0]    r_mod, w_mod_nxt;
  logic                r_val, w_val_nxt;
  logic                r_err, w_err_nxt;

  logic [DATA_W-1:0]   w_word;
  logic [CNT_W-1:0]    w_idx;
  logic [N_W-1:0]      w_n;
  logic                w_full;
  logic                w_illegal;
  logic                w_last;
  logic                w_timeout;

`ifdef DESERIALIZER_LAST_EN
  assign w_last = ser_data_last_i;
`else
  assign w_last = 1'b0;
`endif

  assign w_n       = {1'b0, r_cnt} + N_W'(1);
  assign w_full    = (r_cnt == c_cnt_top);
  assign w_illegal = (w_n >= N_W'(MOD_IGNORE_LO)) && (w_n <= N_W'(MOD_IGNORE_HI));
  assign w_idx     = c_cnt_top - r_cnt;

  // Timeout fires on the idle cycle that would bring the count to GAP_TIMEOUT
  generate
    if (GAP_TIMEOUT > 0) begin : g_gap
      assign w_timeout = (r_state == ST_COLLECT) && !ser_data_val_i &&
                         (r_idle == IDLE_W'(GAP_TIMEOUT - 1));
    end else begin : g_no_gap
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_idle_nxt  = '0;
    w_data_nxt  = r_data;
    w_mod_nxt   = r_mod;
    w_val_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    // A new word always starts from a cleared register
    w_word        = (r_state == ST_IDLE) ? '0 : r_shift;
    w_word[w_idx] = ser_data_i;

    if (ser_data_val_i) begin
      if (w_full || w_last) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
        if (w_full) begin
          w_data_nxt = w_word;
          w_mod_nxt  = '0;
          w_val_nxt  = 1'b1;
        end else if (w_illegal) begin
          w_err_nxt  = 1'b1;
        end else begin
          w_data_nxt = w_word;
          w_mod_nxt  = MOD_W'(w_n);
          w_val_nxt  = 1'b1;
        end
      end else begin
        w_state_nxt = ST_COLLECT;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_shift_nxt = w_word;
      end
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_err_nxt   = 1'b1;
    end else if (r_state == ST_COLLECT) begin
      w_idle_nxt  = r_idle + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idle  <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_idle  <= w_idle_nxt;
      r_data  <= w_data_nxt;
      r_mod   <= w_mod_nxt;
      r_val   <= w_val_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign data_o     = r_data;
  assign data_mod_o = r_mod;
  assign data_val_o = r_val;
  assign err_o      = r_err;
  assign busy_o     = (r_state == ST_COLLECT);

endmodule

`default_nettype wire
